// File: rtl/aes_pkg.sv
// Shared types and constants for the AES-256 key schedule.
package aes_pkg;

    // Key length and round count for AES-256
    localparam int NK = 8;
    localparam int NR = 14;

    // Number of 32-bit words in the expanded schedule
    localparam int NW = 4 * (NR + 1);

    typedef logic [31:0]  word_t;
    typedef logic [127:0] rkey_t;

    // Round constants, only entries 1..7 are reachable for AES-256
    localparam logic [7:0] RCON [1:7] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Cyclic left rotation by one byte
    function automatic word_t rot_word(input word_t w);
        return {w[23:0], w[31:24]};
    endfunction

    // Rcon lookup guarded so index 0 (never used while expanding) yields zero
    function automatic logic [7:0] rcon_of(input logic [2:0] n);
        return (n == 3'd0) ? 8'h00 : RCON[n];
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, one byte in, one byte out.
module aes_sbox (
    input  logic [7:0] i_byte,
    output logic [7:0] o_byte
);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign o_byte = SBOX[i_byte];

endmodule

// File: rtl/aes256_key_expand.sv
// Iterative AES-256 key schedule: one expanded word per clock, round keys
// served through a registered indexed read port.
module aes256_key_expand
    import aes_pkg::*;
#(
    parameter int NK = 8,
    parameter int NR = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [255:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [3:0]   rk_idx,
    output logic [127:0] rk_out,
    output logic         keys_valid
);

    // Only the AES-256 geometry is supported
    generate
        if (NK != aes_pkg::NK || NR != aes_pkg::NR) begin : g_bad_params
            $error("aes256_key_expand supports only NK=8, NR=14");
        end
    endgenerate

    localparam int          RK_COUNT = NR + 1;
    localparam logic [5:0]  I_FIRST  = 6'(NK);
    localparam logic [5:0]  I_LAST   = 6'(NW - 1);

    state_t      r_state;
    logic [5:0]  r_i;
    word_t       r_w [0:NW-1];
    logic        r_key_ready;
    logic        r_keys_valid;
    rkey_t       r_rk_out;

    logic        w_accept;
    logic        w_last;
    word_t       w_prev;
    word_t       w_back;
    word_t       w_sub_in;
    word_t       w_sub_out;
    word_t       w_temp;
    word_t       w_new;
    rkey_t       w_rk_sel;

    assign w_accept = key_valid && r_key_ready;
    assign w_last   = (r_i == I_LAST);
    assign w_prev   = r_w[r_i - 6'd1];
    assign w_back   = r_w[r_i - 6'd8];

    // RotWord is applied ahead of the shared SubWord only on multiples of NK
    assign w_sub_in = (r_i[2:0] == 3'd0) ? rot_word(w_prev) : w_prev;

    // Four S-boxes form the single SubWord datapath shared by every step
    for (genvar b = 0; b < 4; b++) begin : g_subword
        aes_sbox u_sbox (
            .i_byte (w_sub_in[8*b +: 8]),
            .o_byte (w_sub_out[8*b +: 8])
        );
    end

    // Select the word transform for the current index and form w[i]
    always_comb begin
        // NOTE: default assignment first so every path drives w_temp and no latch is inferred.
        w_temp = w_prev;
        if (r_i[2:0] == 3'd0) begin
            w_temp = w_sub_out ^ {rcon_of(r_i[5:3]), 24'h0};
        end else if (r_i[2:0] == 3'd4) begin
            w_temp = w_sub_out;
        end
        w_new = w_back ^ w_temp;
    end

    // Control FSM: key acceptance, word counter and registered status flags
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) begin
            r_state      <= IDLE;
            r_i          <= 6'd0;
            r_key_ready  <= 1'b1;
            r_keys_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_accept) begin
                        r_state      <= EXPAND;
                        r_i          <= I_FIRST;
                        r_key_ready  <= 1'b0;
                        r_keys_valid <= 1'b0;
                    end
                end
                EXPAND: begin
                    if (w_last) begin
                        r_state      <= DONE;
                        r_key_ready  <= 1'b1;
                        r_keys_valid <= 1'b1;
                    end else begin
                        r_i <= r_i + 6'd1;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_i          <= 6'd0;
                    r_key_ready  <= 1'b1;
                    r_keys_valid <= 1'b0;
                end
            endcase
        end
    end

    // Word array: load the cipher key on accept, then append one word per cycle
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is cleared on reset so stale keys never reach rk_out afterwards.
        if (!rst_n) begin
            for (int n = 0; n < NW; n++) begin
                r_w[n] <= '0;
            end
        end else if (w_accept) begin
            for (int n = 0; n < NK; n++) begin
                r_w[n] <= key_in[255 - 32*n -: 32];
            end
        end else if (r_state == EXPAND) begin
            r_w[r_i] <= w_new;
        end
    end

    // Gather the four words of the requested round key; out-of-range reads zero
    always_comb begin
        w_rk_sel = '0;
        if (rk_idx < 4'(RK_COUNT)) begin
            w_rk_sel = {r_w[{rk_idx, 2'd0}], r_w[{rk_idx, 2'd1}],
                        r_w[{rk_idx, 2'd2}], r_w[{rk_idx, 2'd3}]};
        end
    end

    // Registered read port, updated every cycle in every state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rk_out <= '0;
        end else begin
            r_rk_out <= w_rk_sel;
        end
    end

    assign key_ready  = r_key_ready;
    assign keys_valid = r_keys_valid;
    assign rk_out     = r_rk_out;

endmodule
